// File: rtl/atm_pkg.sv
// atm_pkg: shared types and constants for the ATM front-panel controller
package atm_pkg;
   localparam int MSG_W            = 3;
   localparam int DEB_CYCLES_DEF   = 4;
   localparam int RESP_TIMEOUT_DEF = 16;
   typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/atm_debounce.sv
// atm_debounce: 2-flop synchronizer plus stability counter for one raw input
module atm_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [1:0]    r_sync;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   // synchronize, then accept the new value only after DEB_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         if (r_sync[1] == r_level)
            r_cnt <= '0;
         else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else
            r_cnt <= r_cnt + CW'(1);
      end
   end
   assign o_level = r_level;
endmodule

// File: rtl/atm_panel.sv
// atm_panel: debounces card/buttons and issues one key strobe at a time to the ATM controller
module atm_panel import atm_pkg::*; #(
   parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
   parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             card_raw,
   input  logic             a_raw,
   input  logic             b_raw,
   input  logic [MSG_W-1:0] msg,
   output logic             card,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             timeout
);
   localparam int TW = $clog2(RESP_TIMEOUT + 1);
   logic w_card_db, w_a_db, w_b_db, w_pa, w_pb;
   logic w_a, w_b, w_timeout;
   logic r_card, r_a_q, r_b_q, r_a, r_b, r_timeout;
   state_t r_state, w_state;
   logic [MSG_W-1:0] r_snap, w_snap;
   logic [TW-1:0]    r_timer, w_timer;

   atm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_card (.clk(clk), .rst(rst), .i_raw(card_raw), .o_level(w_card_db));
   atm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a    (.clk(clk), .rst(rst), .i_raw(a_raw),    .o_level(w_a_db));
   atm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b    (.clk(clk), .rst(rst), .i_raw(b_raw),    .o_level(w_b_db));

   assign w_pa = w_a_db & ~r_a_q;
   assign w_pb = w_b_db & ~r_b_q;

   // next state: card loss aborts, single press starts a transaction, msg change beats timeout
   always_comb begin
      w_state   = r_state;
      w_snap    = r_snap;
      w_timer   = r_timer;
      w_a       = 1'b0;
      w_b       = 1'b0;
      w_timeout = 1'b0;
      if (!w_card_db)
         w_state = IDLE;
      else if (r_state == IDLE) begin
         if (w_pa ^ w_pb) begin
            w_a     = w_pa;
            w_b     = w_pb;
            w_snap  = msg;
            w_timer = '0;
            w_state = WAIT;
         end
      end else if (msg != r_snap)
         w_state = IDLE;
      else if (r_timer == TW'(RESP_TIMEOUT - 1)) begin
         w_timeout = 1'b1;
         w_state   = IDLE;
      end else
         w_timer = r_timer + TW'(1);
   end

   // state, snapshot, timer, edge history and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_snap    <= '0;
         r_timer   <= '0;
         r_card    <= 1'b0;
         r_a_q     <= 1'b0;
         r_b_q     <= 1'b0;
         r_a       <= 1'b0;
         r_b       <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_snap    <= w_snap;
         r_timer   <= w_timer;
         r_card    <= w_card_db;
         r_a_q     <= w_a_db;
         r_b_q     <= w_b_db;
         r_a       <= w_a;
         r_b       <= w_b;
         r_timeout <= w_timeout;
      end
   end

   assign card    = r_card;
   assign a       = r_a;
   assign b       = r_b;
   assign busy    = (r_state == WAIT);
   assign timeout = r_timeout;
endmodule

// File: tb/tb_atm_panel.sv
// tb_atm_panel: scoreboard bench for the ATM front-panel controller
module tb_atm_panel;
   logic       clk = 1'b0, rst = 1'b1;
   logic       card_raw = 1'b0, a_raw = 1'b0, b_raw = 1'b0;
   logic [2:0] msg = 3'd0;
   logic       card, a, b, busy, timeout;
   int         cyc = 0, n_checks = 0, n_err = 0, k, ks, r;
   logic [17:0] sb_q[$];
   localparam logic [1:0] EV_A = 2'd1, EV_B = 2'd2, EV_TO = 2'd3;

   atm_panel #(.DEB_CYCLES(4), .RESP_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .card_raw(card_raw), .a_raw(a_raw), .b_raw(b_raw),
      .msg(msg), .card(card), .a(a), .b(b), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [17:0] ev(input logic [1:0] t, input int c);
      return {t, c[15:0]};
   endfunction

   task automatic sb_pop(input logic [1:0] t);
      logic [17:0] got;
      got = ev(t, cyc);
      if (sb_q.size() == 0) check("sb_unexpected", {14'd0, got}, 0);
      else check("sb_event", {14'd0, got}, {14'd0, sb_q.pop_front()});
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // output monitor: every strobe or timeout pulse must match the next expected event
   always @(negedge clk) begin
      if (!rst) begin
         check("excl", {31'd0, (a & b) | ((a | b) & ~card)}, 0);
         if (a) sb_pop(EV_A);
         if (b) sb_pop(EV_B);
         if (timeout) sb_pop(EV_TO);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) begin
         @(negedge clk);
         check("rst_outs", {27'd0, card, a, b, busy, timeout}, 0);
         {card_raw, a_raw, b_raw} = 3'($urandom);
      end
      @(negedge clk);
      {card_raw, a_raw, b_raw} = 3'd0;
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("idle_outs", {27'd0, card, a, b, busy, timeout}, 0);
      end
      card_raw = 1'b1;
      repeat (2) @(negedge clk);
      card_raw = 1'b0;
      repeat (2) @(negedge clk);
      card_raw = 1'b1;
      ks = cyc + 1;
      while (cyc < ks + 7) begin
         @(negedge clk);
         check("card_deb", {31'd0, card}, {31'd0, cyc >= ks + 6});
      end
      a_raw = 1'b1;
      k = cyc + 1;
      sb_q.push_back(ev(EV_A, k + 6));
      to_cyc(k + 6);
      check("hs_a", {31'd0, a}, 1);
      check("hs_busy", {31'd0, busy}, 1);
      to_cyc(k + 9);
      msg = 3'd3;
      check("hs_busy_hold", {31'd0, busy}, 1);
      to_cyc(k + 10);
      check("hs_busy_fall", {31'd0, busy}, 0);
      check("hs_no_to", {31'd0, timeout}, 0);
      a_raw = 1'b0;
      repeat (10) @(negedge clk);
      b_raw = 1'b1;
      k = cyc + 1;
      sb_q.push_back(ev(EV_B, k + 6));
      sb_q.push_back(ev(EV_TO, k + 22));
      to_cyc(k + 6);
      check("to_busy", {31'd0, busy}, 1);
      to_cyc(k + 8);
      a_raw = 1'b1;
      to_cyc(k + 21);
      check("to_busy_hold", {31'd0, busy}, 1);
      to_cyc(k + 22);
      check("to_pulse", {31'd0, timeout}, 1);
      check("to_busy_fall", {31'd0, busy}, 0);
      a_raw = 1'b0;
      b_raw = 1'b0;
      repeat (10) @(negedge clk);
      a_raw = 1'b1;
      b_raw = 1'b1;
      repeat (12) @(negedge clk);
      check("rej_both_busy", {31'd0, busy}, 0);
      a_raw = 1'b0;
      b_raw = 1'b0;
      repeat (10) @(negedge clk);
      card_raw = 1'b0;
      repeat (10) @(negedge clk);
      check("rej_card_low", {31'd0, card}, 0);
      a_raw = 1'b1;
      repeat (12) @(negedge clk);
      check("rej_nocard_busy", {31'd0, busy}, 0);
      a_raw = 1'b0;
      repeat (10) @(negedge clk);
      card_raw = 1'b1;
      repeat (10) @(negedge clk);
      check("ab_card", {31'd0, card}, 1);
      a_raw = 1'b1;
      k = cyc + 1;
      sb_q.push_back(ev(EV_A, k + 6));
      to_cyc(k + 6);
      check("ab_busy", {31'd0, busy}, 1);
      to_cyc(k + 7);
      card_raw = 1'b0;
      to_cyc(k + 13);
      check("ab_busy_hold", {31'd0, busy}, 1);
      to_cyc(k + 14);
      check("ab_busy_fall", {31'd0, busy}, 0);
      check("ab_card_fall", {31'd0, card}, 0);
      a_raw = 1'b0;
      to_cyc(k + 30);
      card_raw = 1'b1;
      repeat (10) @(negedge clk);
      b_raw = 1'b1;
      k = cyc + 1;
      sb_q.push_back(ev(EV_B, k + 6));
      to_cyc(k + 6);
      check("rm_busy", {31'd0, busy}, 1);
      to_cyc(k + 8);
      rst = 1'b1;
      to_cyc(k + 9);
      check("rm_outs", {27'd0, card, a, b, busy, timeout}, 0);
      to_cyc(k + 10);
      rst = 1'b0;
      r = cyc;
      sb_q.push_back(ev(EV_B, r + 7));
      to_cyc(r + 7);
      check("rm_rebusy", {31'd0, busy}, 1);
      to_cyc(r + 9);
      msg = 3'd5;
      to_cyc(r + 10);
      check("rm_busy_fall", {31'd0, busy}, 0);
      b_raw = 1'b0;
      repeat (30) @(negedge clk);
      check("sb_drain", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
